// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and fetch-entry type for the fetch stage
// Purpose: default widths/sizes used by the fetch unit, its interface and its bench,
//          plus the entry record handed from fetch to decode.
// Ports:   none (package).
package fetch_unit_pkg;

   localparam int XLEN       = 64;
   localparam int ILEN       = 32;
   localparam int IMEM_DEPTH = 1024;
   localparam logic [XLEN-1:0] RESET_PC = '0;

   // One decoded-side record: the PC, the fetched word (0 on a fault) and the fault tag.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            inv_addr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - redirect, instruction-memory and decode-side signals of the fetch unit
// Purpose: bundles every non-clock/reset signal of fetch_unit.
// Ports:   master = fetch_unit side (drives imem_req/imem_addr, out_*, halted);
//          slave  = environment side (drives redirect_*, imem_rdata, out_ready).
interface fetch_unit_if #(
   parameter int XLEN = fetch_unit_pkg::XLEN,
   parameter int AW   = 10
);
   import fetch_unit_pkg::*;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req;
   logic [AW-1:0]   imem_addr;
   logic [ILEN-1:0] imem_rdata;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [ILEN-1:0] out_instr;
   logic            out_inv_addr;
   logic            halted;

   modport master (
      input  redirect_valid, redirect_pc, imem_rdata, out_ready,
      output imem_req, imem_addr, out_valid, out_pc, out_instr, out_inv_addr, halted
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_rdata, out_ready,
      input  imem_req, imem_addr, out_valid, out_pc, out_instr, out_inv_addr, halted
   );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO buffering fetched entries ahead of decode
// Purpose: DEPTH-entry FIFO with push, pop, flush and occupancy count.
// Ports:   clk, rst_n (async active-low); push/push_data write an entry;
//          pop removes the head (ignored when empty); flush empties the FIFO
//          and overrides push/pop; count = occupancy; head_valid/head_data = head entry.
module fetch_fifo #(
   parameter int DW    = 97,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [DW-1:0]              push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       head_valid,
   output logic [DW-1:0]              head_data
);
   import fetch_unit_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          do_pop;

   assign head_valid = (count_q != '0);
   assign do_pop     = pop && head_valid;
   assign head_data  = mem[rd_ptr];
   assign count      = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_q + CW'(push) - CW'(do_pop);
      end
   end

   // The issuing side reserves a slot before it reads memory, so a push never finds the FIFO full.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !flush && !do_pop && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - pipelined instruction fetch stage with fault tagging and redirect
// Purpose: holds the fetch PC, reads one 32-bit word per cycle from a synchronous
//          instruction memory, buffers {pc, instr, fault} in fetch_fifo for decode,
//          halts after issuing an invalid-address entry and resumes on redirect.
// Ports:   clk, rst_n (async active-low);
//          bus.redirect_valid/redirect_pc - load new PC and flush younger work;
//          bus.imem_req/imem_addr/imem_rdata - memory read, data one cycle after req;
//          bus.out_valid/out_ready/out_pc/out_instr/out_inv_addr - decode handshake;
//          bus.halted - fetch stopped on a fault.
module fetch_unit #(
   parameter int              XLEN       = fetch_unit_pkg::XLEN,
   parameter int              IMEM_DEPTH = fetch_unit_pkg::IMEM_DEPTH,
   parameter logic [XLEN-1:0] RESET_PC   = fetch_unit_pkg::RESET_PC,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);
   import fetch_unit_pkg::*;

   localparam int AW = $clog2(IMEM_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = XLEN + ILEN + 1;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   logic [0:0]      state;
   logic [XLEN-1:0] fetch_pc;
   logic            s1_valid;
   logic [XLEN-1:0] s1_pc;
   logic            s1_fault;

   logic            bad;
   logic            deq;
   logic [CW:0]     occ;
   logic            issue;
   logic [CW-1:0]   fifo_count;
   logic            head_valid;
   logic [EW-1:0]   push_data;
   logic [EW-1:0]   head_data;

   // IMEM_DEPTH is a power of two, so "word index >= IMEM_DEPTH" is any bit set above the index.
   assign bad = (fetch_pc[1:0] != 2'b00) || (|fetch_pc[XLEN-1:AW+2]);

   assign deq = head_valid & bus.out_ready;

   // Slots that will be taken after this edge: queued entries minus the one leaving,
   // plus the read already in flight. Issue only if one more still fits.
   assign occ   = {1'b0, fifo_count} + (CW+1)'(s1_valid) - (CW+1)'(deq);
   assign issue = (state == ST_RUN) && (occ < (CW+1)'(FIFO_DEPTH)) && !bus.redirect_valid;

   // Gated by rst_n so the strobe stays low while reset is held.
   assign bus.imem_req  = rst_n && issue && !bad;
   assign bus.imem_addr = fetch_pc[2 +: AW];
   assign bus.halted    = (state == ST_HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         fetch_pc <= RESET_PC;
         s1_valid <= 1'b0;
         s1_pc    <= '0;
         s1_fault <= 1'b0;
      end else if (bus.redirect_valid) begin
         state    <= ST_RUN;
         fetch_pc <= bus.redirect_pc;
         s1_valid <= 1'b0;
      end else if (issue) begin
         s1_valid <= 1'b1;
         s1_pc    <= fetch_pc;
         s1_fault <= bad;
         if (bad) state <= ST_HALT;
         else     fetch_pc <= fetch_pc + XLEN'(4);
      end else begin
         s1_valid <= 1'b0;
      end
   end

   // A fault entry carries no memory data: no read was issued for it.
   assign push_data = {s1_pc, (s1_fault ? ILEN'(0) : bus.imem_rdata), s1_fault};

   fetch_fifo #(
      .DW    (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (s1_valid),
      .push_data  (push_data),
      .pop        (deq),
      .flush      (bus.redirect_valid),
      .count      (fifo_count),
      .head_valid (head_valid),
      .head_data  (head_data)
   );

   assign bus.out_valid = head_valid;
   assign {bus.out_pc, bus.out_instr, bus.out_inv_addr} = head_data;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
// Purpose: directed scenarios plus randomized ready/redirect traffic checked against
//          a sequence-level model of the fetch stream.
// Ports:   none (top-level bench).
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int DEPTH = IMEM_DEPTH;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_unit_if #(.XLEN(XLEN), .AW(10)) bus ();

   fetch_unit #(
      .XLEN       (XLEN),
      .IMEM_DEPTH (DEPTH),
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] imem [DEPTH];

   // Synchronous memory; returns garbage when not read so stale data is visible.
   always @(posedge clk) bus.imem_rdata <= bus.imem_req ? imem[bus.imem_addr] : $urandom;

   int n_checks = 0;
   int n_fail   = 0;
   int seg_hs   = 0;

   // Model: the next entry decode should accept is exp_pc; after a fault entry nothing
   // more is expected until a redirect (or reset) restarts the stream.
   logic [63:0] exp_pc;
   logic        exp_done;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic model_step();
      fetch_entry_t e;
      if (bus.halted) check("halt_no_req", 64'(bus.imem_req), 64'd0);
      if (bus.out_valid && bus.out_ready) begin
         seg_hs++;
         if (exp_done) begin
            check("entry_after_fault", 64'(bus.out_valid), 64'd0);
         end else begin
            e.pc       = exp_pc;
            e.inv_addr = (exp_pc[1:0] != 2'b00) || (exp_pc >= 64'(DEPTH * 4));
            e.instr    = e.inv_addr ? 32'd0 : imem[exp_pc[2 +: 10]];
            check("out_pc", bus.out_pc, e.pc);
            check("out_instr", 64'(bus.out_instr), 64'(e.instr));
            check("out_inv_addr", 64'(bus.out_inv_addr), 64'(e.inv_addr));
            if (e.inv_addr) begin
               check("fault_halted", 64'(bus.halted), 64'd1);
               exp_done = 1'b1;
            end else begin
               exp_pc = exp_pc + 64'd4;
            end
         end
      end
      if (bus.redirect_valid) begin
         exp_pc   = bus.redirect_pc;
         exp_done = 1'b0;
      end
   endtask

   task automatic cyc(input logic rv, input logic [63:0] rpc, input logic rdy);
      @(negedge clk);
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.out_ready      = rdy;
      #1;
      model_step();
   endtask

   initial begin
      logic [63:0] t;
      logic        rv;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.out_ready      = 1'b0;
      exp_pc   = RESET_PC;
      exp_done = 1'b0;
      for (int i = 0; i < DEPTH; i++) imem[i] = $urandom;
      imem[0] = 32'hA000_000A;
      imem[1] = 32'hB000_000B;
      imem[2] = 32'hC000_000C;
      imem[3] = 32'hD000_000D;

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst_imem_req", 64'(bus.imem_req), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_pc", bus.out_pc, 64'd0);
      check("rst_out_instr", 64'(bus.out_instr), 64'd0);
      check("rst_out_inv", 64'(bus.out_inv_addr), 64'd0);
      check("rst_halted", 64'(bus.halted), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Streaming from reset: one entry per cycle from cycle 3
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 64'd0, 1'b1);
         if (i <= 4) begin
            check("t1_req", 64'(bus.imem_req), 64'd1);
            check("t1_addr", 64'(bus.imem_addr), 64'(i - 1));
         end
         if (i < 3) check("t1_early_valid", 64'(bus.out_valid), 64'd0);
         else if (i <= 6) begin
            check("t1_valid", 64'(bus.out_valid), 64'd1);
            check("t1_pc", bus.out_pc, 64'((i - 3) * 4));
         end
      end

      // Backpressure: FIFO fills to 2 and fetch stops
      cyc(1'b1, 64'h10, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         cyc(1'b0, 64'd0, 1'b0);
         if (k >= 5) begin
            check("bp_req", 64'(bus.imem_req), 64'd0);
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_head", bus.out_pc, 64'h10);
            check("bp_count", 64'(dut.fifo_count), 64'd2);
         end
      end
      seg_hs = 0;
      for (int k = 1; k <= 8; k++) cyc(1'b0, 64'd0, 1'b1);
      check("bp_release_stream", 64'(seg_hs), 64'd8);

      // Redirect with entries queued and a read in flight
      cyc(1'b0, 64'd0, 1'b1);
      check("rd_pre_valid", 64'(bus.out_valid), 64'd1);
      cyc(1'b1, 64'h40, 1'b1);
      check("rd_cycle_req", 64'(bus.imem_req), 64'd0);
      cyc(1'b0, 64'd0, 1'b1);
      check("rd_n1_valid", 64'(bus.out_valid), 64'd0);
      check("rd_n1_req", 64'(bus.imem_req), 64'd1);
      check("rd_n1_addr", 64'(bus.imem_addr), 64'h10);
      cyc(1'b0, 64'd0, 1'b1);
      check("rd_n2_valid", 64'(bus.out_valid), 64'd0);
      cyc(1'b0, 64'd0, 1'b1);
      check("rd_n3_valid", 64'(bus.out_valid), 64'd1);
      check("rd_n3_pc", bus.out_pc, 64'h40);

      // Misaligned redirect: single fault entry, halt until redirect
      cyc(1'b1, 64'h42, 1'b0);
      cyc(1'b0, 64'd0, 1'b0);
      check("mis_n1_req", 64'(bus.imem_req), 64'd0);
      check("mis_n1_halted", 64'(bus.halted), 64'd0);
      cyc(1'b0, 64'd0, 1'b0);
      check("mis_n2_halted", 64'(bus.halted), 64'd1);
      check("mis_n2_valid", 64'(bus.out_valid), 64'd0);
      cyc(1'b0, 64'd0, 1'b0);
      check("mis_valid", 64'(bus.out_valid), 64'd1);
      check("mis_pc", bus.out_pc, 64'h42);
      check("mis_inv", 64'(bus.out_inv_addr), 64'd1);
      check("mis_instr", 64'(bus.out_instr), 64'd0);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 64'd0, 1'b0);
         check("mis_hold_halted", 64'(bus.halted), 64'd1);
         check("mis_hold_valid", 64'(bus.out_valid), 64'd1);
      end
      cyc(1'b0, 64'd0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 64'd0, 1'b1);
         check("mis_drained", 64'(bus.out_valid), 64'd0);
         check("mis_no_req", 64'(bus.imem_req), 64'd0);
      end
      cyc(1'b1, 64'h100, 1'b1);
      cyc(1'b0, 64'd0, 1'b1);
      check("resume_req", 64'(bus.imem_req), 64'd1);
      check("resume_addr", 64'(bus.imem_addr), 64'h40);
      check("resume_halted", 64'(bus.halted), 64'd0);

      // End of memory: 0xFF8, 0xFFC valid, 0x1000 faults
      cyc(1'b1, 64'hFF8, 1'b1);
      seg_hs = 0;
      for (int k = 0; k < 10; k++) cyc(1'b0, 64'd0, 1'b1);
      check("end_entries", 64'(seg_hs), 64'd3);
      check("end_halted", 64'(bus.halted), 64'd1);
      check("end_valid", 64'(bus.out_valid), 64'd0);

      // Asynchronous reset mid-stream
      cyc(1'b1, 64'h200, 1'b0);
      for (int k = 0; k < 4; k++) cyc(1'b0, 64'd0, 1'b0);
      check("ar_pre_valid", 64'(bus.out_valid), 64'd1);
      #2 rst_n = 1'b0;
      exp_pc   = RESET_PC;
      exp_done = 1'b0;
      #1;
      check("ar_valid", 64'(bus.out_valid), 64'd0);
      check("ar_pc", bus.out_pc, 64'd0);
      check("ar_req", 64'(bus.imem_req), 64'd0);
      check("ar_halted", 64'(bus.halted), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b0, 64'd0, 1'b1);
         if (i == 1) check("ar_restart_addr", 64'(bus.imem_addr), 64'(RESET_PC >> 2));
         if (i == 3) begin
            check("ar_restart_valid", 64'(bus.out_valid), 64'd1);
            check("ar_restart_pc", bus.out_pc, RESET_PC);
         end
      end

      // Random ready / redirect traffic
      seg_hs = 0;
      for (int n = 0; n < 3000; n++) begin
         rv = bus.halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0);
         case ($urandom_range(0, 7))
            0:       t = 64'($urandom_range(0, 1023) * 4 + $urandom_range(1, 3));
            1:       t = 64'h1000 + 64'($urandom_range(0, 1000) * 4);
            2:       t = 64'h1000 - 64'($urandom_range(1, 4) * 4);
            3:       t = 64'hFFFF_FFFF_FFFF_FFFC;
            default: t = 64'($urandom_range(0, 1023) * 4);
         endcase
         cyc(rv, t, ($urandom_range(0, 3) != 0));
      end
      check("random_progress", 64'(seg_hs > 300), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Pipelined, parametrised instruction fetch stage. It holds the fetch PC and issues word reads to a synchronous instruction memory. Each returned instruction is buffered with its PC in a small FIFO and handed to decode over a valid/ready handshake. It checks alignment and range, reports an invalid address as a tagged fault entry, halts on a fault, and resumes on a redirect from branch/jump resolution.

Parameters:
XLEN, 64, PC width in bits
IMEM_DEPTH, 1024, instruction memory depth in 32-bit words (power of two)
RESET_PC, 0, fetch PC after reset
FIFO_DEPTH, 2, output buffer entries (>=2, power of two)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  load new PC, flush everything younger
redirect_pc  in  XLEN  redirect target
imem_req  out  1  read strobe to instruction memory
imem_addr  out  $clog2(IMEM_DEPTH)  word index (fetch_pc[2+:AW])
imem_rdata  in  32  read data, valid exactly 1 cycle after imem_req
out_valid  out  1  FIFO head valid
out_ready  in  1  decode accepts head
out_pc  out  XLEN  PC of head entry
out_instr  out  32  instruction of head entry (0 on fault)
out_inv_addr  out  1  head entry is an invalid-address fault
halted  out  1  state == HALT

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, state=RUN, FIFO empty, s1_valid=0. Outputs imem_req=0, out_valid=0, out_pc=0, out_instr=0, out_inv_addr=0, halted=0.
- Address check (combinational on fetch_pc): bad = fetch_pc[1:0]!=0 OR fetch_pc[XLEN-1:2] >= IMEM_DEPTH.
- Space: deq = out_valid & out_ready. Issue is allowed when count - deq + s1_valid < FIFO_DEPTH.
- RUN, issue allowed, !redirect_valid:
  - If !bad: imem_req=1, s1 <= {valid=1, pc=fetch_pc, fault=0}, fetch_pc <= fetch_pc+4 (modulo 2^XLEN).
  - If bad: imem_req=0, s1 <= {valid=1, pc=fetch_pc, fault=1}, state <= HALT, fetch_pc unchanged.
- Issue not allowed: imem_req=0, s1_valid <= 0, fetch_pc holds.
- Stage 1: when s1_valid, push {s1_pc, fault ? 0 : imem_rdata, fault} into the FIFO. Space is guaranteed by the credit rule, so overflow is impossible. This is an assertion.
- Latency: redirect at cycle N gives imem_req at N+1 and the earliest out_valid at N+3. With FIFO_DEPTH>=2 and out_ready held at 1, throughput is 1 instruction per cycle.
- HALT: no issue. Entries already queued drain normally. Leave HALT only by redirect.
- redirect_valid (highest priority, any state):
  - fetch_pc <= redirect_pc, state <= RUN.
  - s1_valid <= 0, so the in-flight read is discarded and imem_rdata is ignored next cycle.
  - FIFO is flushed (count <= 0).
  - imem_req=0 in the redirect cycle.
  - A head handshake (out_valid & out_ready) in the same cycle still counts as accepted by decode.
- Boundary: last valid word (IMEM_DEPTH-1)*4 fetches normally. The next PC is out of range, giving a fault entry and HALT. A PC wrapping past 2^XLEN-4 to 0 is legal.
- A redirect to a misaligned or out-of-range target produces a fault entry with pc=redirect_pc on the next cycle.
- Reset asserted mid-operation clears all state immediately. In-flight data is dropped.

Decomposition:
- Shared package: XLEN, instruction width 32, IMEM_DEPTH, RESET_PC, and the fetch-entry struct {pc, instr, inv_addr}.
- One sub-module, fetch_fifo: parametrised sync FIFO with push, pop, flush, count, head outputs and async active-low reset.
- The PC/issue/FSM logic stays in fetch_unit.

Test Plan:
- Reset, out_ready=1, imem[0..3]=A,B,C,D: out_pc 0,4,8,C emitted on consecutive cycles from cycle 3; imem_addr 0,1,2,3.
- Backpressure: out_ready=0 for 10 cycles after 2 entries: imem_req deasserts, count stays 2, no entry is lost. Release gives an in-order stream with no duplicates.
- Redirect to 0x40 while 2 entries are queued and a read is in flight: FIFO empties, the stale rdata is dropped, and the next out_pc is 0x40 three cycles later.
- Redirect to 0x42: one entry {pc=0x42, instr=0, inv_addr=1}, halted=1, and imem_req stays 0 until a redirect to 0x100 resumes fetch.
- Sequential run from 0xFF8 with IMEM_DEPTH=1024: entries at 0xFF8 and 0xFFC are valid, then a fault entry at pc 0x1000, then HALT.
- rst_n pulsed low mid-stream while out_valid=1: out_valid drops asynchronously, and after release fetch restarts at RESET_PC.
